timer_irq_bank: RTL and testbench
=================================

# timer_irq_bank

Parametrised multi-channel timer/interrupt peripheral on the CPU data bus, sitting beside `Peripheral` and driven by the same `MemAddr`/`MemRead`/`MemWrite` signals from `pipeline_core`. It generalises the single TH/TL/TCON timer to `CHANNELS` independent counters of `WIDTH` bits. Each channel can run in auto-reload or one-shot mode. Per-channel interrupt lines are ORed onto one `irqout` for the core's `iInterrupt`.

## Interface
- `CHANNELS`, default 2: number of timer channels, 1..8.
- `WIDTH`, default 32: counter width, 8..32.
- `BASE_ADDR`, default 32'h4000_0000: byte address of channel 0.
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `reset` input, 1 bit: synchronous, active-low; sampled on the `clk` rising edge.
- `rd` input, 1 bit: bus read strobe.
- `wr` input, 1 bit: bus write strobe.
- `addr` input, 32 bits: byte address; `addr[1:0]` ignored.
- `wdata` input, 32 bits: write data.
- `rdata` output, 32 bits: read data, combinational.
- `irq_vec` output, `CHANNELS` bits: per-channel interrupt request.
- `irqout` output, 1 bit: OR of `irq_vec`.

## Operation
- Channel n occupies a 16-byte window at `BASE_ADDR + 16*n`:
  - +0: TH, the reload value.
  - +4: TL, the counter.
  - +8: TCON.
  - +12: unmapped.
- TCON bits:
  - bit0 EN: counter enable.
  - bit1 IE: interrupt enable.
  - bit2 ST: interrupt status, write-1-to-clear.
  - bit3 OS: one-shot mode.
  - bits 31:4 read 0.
- Hit: upper address bits match `BASE_ADDR` and channel index `addr[6:4] < CHANNELS`. Anything else is unmapped: reads 0, writes ignored.
- Writes (`wr`=1, hit):
  - TH and TL take `wdata[WIDTH-1:0]`.
  - TCON writes EN, IE and OS directly.
  - `wdata[2]`=1 clears ST; writing 0 to bit2 leaves ST unchanged.
- Reads (`rd`=1, hit): `rdata` is the register value, zero-extended to 32 bits. When `rd`=0, `rdata`=0. `rd` and `wr` to the same address in one cycle: `rdata` shows the pre-write value.
- Counting: while EN=1, TL increments by 1 each cycle.
- Overflow event for a channel: EN=1 and TL = 2^WIDTH−1 and no bus write to that channel's TL this cycle. On the event:
  - TL <= TH.
  - ST <= 1 if IE=1; if IE=0, ST is unchanged.
  - If OS=1, EN <= 0 (TL still reloads).
- Precedence within one channel, highest first:
  1. reset
  2. bus write to TL (beats increment and reload; no overflow event)
  3. overflow reload
  4. increment
- ST precedence: setting by an overflow event beats a W1C clear in the same cycle, so no event is lost.
- A TCON write with EN=0 that coincides with an overflow event: the reload still happens, and EN ends at 0.
- `irq_vec[n]` = ST[n] & IE[n]. `irqout` = |`irq_vec`. Both are decoded from registered state only.
- Channels are fully independent. Simultaneous overflows on several channels each set their own ST.

## Timing
- Reset (`reset`=0 at an edge): after that edge TH, TL and TCON of every channel are 0, and `irq_vec`=0, `irqout`=0. `rdata` is 0 unless a read is issued.
- A reset asserted mid-count takes effect at that edge. No overflow or write lands in the same cycle.
- Write latency is 1 cycle: the value is readable from the cycle after the `wr` edge.
- Count: if TL=v at edge k with EN=1, then TL=v+1 after edge k.
- Overflow: TL=max sampled at edge k gives TL=TH, ST=1 and `irqout`=1 immediately after edge k.
- Auto-reload period is 2^WIDTH − TH cycles.
- Enabling: a TCON write setting EN at edge k means the first increment happens at edge k+1.
- Interrupt clear: a W1C at edge k drops `irqout` after edge k, unless the same-cycle set rule applies.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with random bus traffic -> all reads return 0, `irqout`=0, `irq_vec`=0.
- Auto-reload, channel 0, WIDTH=32:
  - Stimulus: TH=0xFFFF_FFFC, TL=0xFFFF_FFFE, TCON=0x3.
  - Required TL sequence: FFFF_FFFF, FFFF_FFFC, FD, FE, FF, FC …
  - `irqout` rises on the cycle TL first returns to FFFF_FFFC and stays high until W1C `wdata`=0x4.
- One-shot: TH=5, TL=0xFFFF_FFFF, TCON=0xB -> next cycle TL=5, TCON reads 0xE (EN cleared, ST set), and TL then holds 5.
- Collision: a W1C on TCON issued on the exact overflow edge -> ST stays 1, `irqout` stays 1. A W1C one cycle later -> `irqout`=0.
- TL write vs overflow: write TL=0x10 on the cycle TL=max -> TL=0x10 and ST=0.
- Multi-channel, CHANNELS=4:
  - Stimulus: channels 1 and 2 overflow in the same cycle; channel 1 has IE=1, channel 2 has IE=0.
  - Required: `irq_vec`=4'b0010, `irqout`=1, and channel 2 ST=0.
  - A read of `BASE_ADDR+0x40` returns 0.

Source files
------------

// File: rtl/timer_irq_bank.sv
// timer_irq_bank: CHANNELS independent WIDTH-bit timers on the CPU data bus.
// Each channel exposes TH (reload), TL (counter) and TCON (EN/IE/ST/OS) in a
// 16-byte window. Per-channel interrupts are ORed onto irqout.
module timer_irq_bank #(
  parameter int          CHANNELS  = 2,
  parameter int          WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rd,
  input  logic                wr,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic [CHANNELS-1:0] irq_vec,
  output logic                irqout
);

  // Register offsets within a channel window (word index, addr[3:2]).
  localparam logic [1:0]       REG_TH   = 2'd0;
  localparam logic [1:0]       REG_TL   = 2'd1;
  localparam logic [1:0]       REG_TCON = 2'd2;
  localparam logic [3:0]       CH_COUNT = 4'(CHANNELS);
  localparam logic [WIDTH-1:0] TL_MAX   = {WIDTH{1'b1}};

  // Bus decode shared by all channels. The 8-channel address space spans
  // addr[6:0], so the base match covers addr[31:7].
  logic [2:0] ch_idx;
  logic [1:0] reg_sel;
  logic       base_match;
  logic       hit;

  assign ch_idx     = addr[6:4];
  assign reg_sel    = addr[3:2];
  assign base_match = (addr[31:7] == BASE_ADDR[31:7]);
  assign hit        = base_match && ({1'b0, ch_idx} < CH_COUNT);

  // Byte-lane bits and wdata bits above WIDTH carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata};

  // Per-channel read value, already zero-extended to the bus width.
  logic [31:0] ch_rdata [CHANNELS];

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [WIDTH-1:0] th_reg, th_next;
      logic [WIDTH-1:0] tl_reg, tl_next;
      logic             en_reg, en_next;
      logic             ie_reg, ie_next;
      logic             st_reg, st_next;
      logic             os_reg, os_next;

      logic             sel;
      logic             wr_th;
      logic             wr_tl;
      logic             wr_tcon;
      logic             overflow;
      logic [31:0]      tcon_val;
      logic [31:0]      reg_rdata;

      assign sel     = hit && (ch_idx == 3'(gi));
      assign wr_th   = wr && sel && (reg_sel == REG_TH);
      assign wr_tl   = wr && sel && (reg_sel == REG_TL);
      assign wr_tcon = wr && sel && (reg_sel == REG_TCON);

      // A bus write to TL suppresses the overflow event entirely, so software
      // can always reposition the counter without a spurious interrupt.
      assign overflow = en_reg && (tl_reg == TL_MAX) && !wr_tl;

      // Next-state: TL write > overflow reload > increment; overflow set of
      // ST wins over a same-cycle W1C so no interrupt is lost.
      always_comb begin
        th_next = th_reg;
        tl_next = tl_reg;
        en_next = en_reg;
        ie_next = ie_reg;
        st_next = st_reg;
        os_next = os_reg;

        if (wr_th) begin
          th_next = wdata[WIDTH-1:0];
        end

        if (wr_tl) begin
          tl_next = wdata[WIDTH-1:0];
        end else if (overflow) begin
          tl_next = th_reg;
        end else if (en_reg) begin
          tl_next = tl_reg + WIDTH'(1);
        end

        if (wr_tcon) begin
          en_next = wdata[0];
          ie_next = wdata[1];
          os_next = wdata[3];
          if (wdata[2]) begin
            st_next = 1'b0;
          end
        end

        if (overflow) begin
          if (ie_reg) begin
            st_next = 1'b1;
          end
          // One-shot stops after the reload; a coinciding EN=0 write also
          // lands at 0, so both paths agree.
          if (os_reg) begin
            en_next = 1'b0;
          end
        end
      end

      // Channel state register with synchronous active-low reset.
      always_ff @(posedge clk) begin
        if (!reset) begin
          th_reg <= '0;
          tl_reg <= '0;
          en_reg <= 1'b0;
          ie_reg <= 1'b0;
          st_reg <= 1'b0;
          os_reg <= 1'b0;
        end else begin
          th_reg <= th_next;
          tl_reg <= tl_next;
          en_reg <= en_next;
          ie_reg <= ie_next;
          st_reg <= st_next;
          os_reg <= os_next;
        end
      end

      assign tcon_val = {28'd0, os_reg, st_reg, ie_reg, en_reg};

      // Register select for this channel; the +12 slot reads as zero.
      always_comb begin
        reg_rdata = '0;
        case (reg_sel)
          REG_TH:   reg_rdata = 32'(th_reg);
          REG_TL:   reg_rdata = 32'(tl_reg);
          REG_TCON: reg_rdata = tcon_val;
          default:  reg_rdata = '0;
        endcase
      end

      assign ch_rdata[gi] = reg_rdata;
      assign irq_vec[gi]  = st_reg & ie_reg;
    end
  endgenerate

  // Read mux: only a strobed read of a mapped channel drives the bus. State is
  // registered, so a same-cycle write is not visible until the next cycle.
  always_comb begin
    rdata = '0;
    if (rd && hit) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (ch_idx == i[2:0]) begin
          rdata = ch_rdata[i];
        end
      end
    end
  end

  assign irqout = |irq_vec;

endmodule

// File: tb/tb_timer_irq_bank.sv
// Directed bench for timer_irq_bank (4 channels, 32-bit): expected values are
// queued when a step is driven and popped when the DUT output is sampled.
module tb_timer_irq_bank;

  localparam int          CH = 4;
  localparam int          W  = 32;
  localparam logic [31:0] B  = 32'h4000_0000;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          rd    = 1'b0;
  logic          wr    = 1'b0;
  logic [31:0]   addr  = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic [CH-1:0] irq_vec;
  logic          irqout;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  timer_irq_bank #(
    .CHANNELS (CH),
    .WIDTH    (W),
    .BASE_ADDR(B)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .rd     (rd),
    .wr     (wr),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq_vec(irq_vec),
    .irqout (irqout)
  );

  always #50 clk = ~clk;

  function automatic logic [31:0] ra(input int ch, input int off);
    return B + 32'(ch * 16 + off);
  endfunction

  task automatic expect_val(input string tag, input logic [31:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic compare_next(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  // Step to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    tick();
    wr    = 1'b0;
  endtask

  task automatic check_read(input string tag, input logic [31:0] a, input logic [31:0] e);
    expect_val(tag, e);
    addr = a;
    rd   = 1'b1;
    #1;
    compare_next(rdata);
    rd   = 1'b0;
  endtask

  task automatic check_irq(input string tag, input logic [CH-1:0] vec_e);
    expect_val({tag, "_vec"}, 32'(vec_e));
    expect_val({tag, "_irqout"}, 32'(|vec_e));
    #1;
    compare_next(32'(irq_vec));
    compare_next(32'(irqout));
  endtask

  logic [31:0]   ar_tl  [6];
  logic [CH-1:0] ar_irq [6];

  initial begin
    ar_tl  = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'hFFFF_FFFD,
               32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
    ar_irq = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};

    // Reset held for two cycles under random bus traffic.
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wr    = 1'($urandom_range(0, 1));
      rd    = 1'($urandom_range(0, 1));
      addr  = B + 32'($urandom_range(0, 15) * 4);
      wdata = $urandom;
      tick();
    end
    wr    = 1'b0;
    rd    = 1'b0;
    reset = 1'b1;
    for (int c = 0; c < CH; c++) begin
      for (int o = 0; o < 12; o += 4) begin
        check_read($sformatf("reset_ch%0d_off%0d", c, o), ra(c, o), 32'h0);
      end
    end
    check_irq("reset", 4'b0000);

    // Auto-reload on channel 0.
    bus_write(ra(0, 0), 32'hFFFF_FFFC);
    bus_write(ra(0, 4), 32'hFFFF_FFFE);
    bus_write(ra(0, 8), 32'h3);
    check_read("ar_tl_start", ra(0, 4), 32'hFFFF_FFFE);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_read($sformatf("ar_tl_%0d", i), ra(0, 4), ar_tl[i]);
      check_irq($sformatf("ar_irq_%0d", i), ar_irq[i]);
    end
    bus_write(ra(0, 8), 32'h4);
    check_irq("ar_w1c", 4'b0000);
    check_read("ar_tcon_after_w1c", ra(0, 8), 32'h0);
    check_read("ar_tl_after_w1c", ra(0, 4), 32'hFFFF_FFFD);

    // One-shot on channel 0.
    bus_write(ra(0, 0), 32'h5);
    bus_write(ra(0, 4), 32'hFFFF_FFFF);
    bus_write(ra(0, 8), 32'hB);
    check_read("os_tl_armed", ra(0, 4), 32'hFFFF_FFFF);
    tick();
    check_read("os_tl_reload", ra(0, 4), 32'h5);
    check_read("os_tcon", ra(0, 8), 32'hE);
    check_irq("os_irq", 4'b0001);
    tick();
    check_read("os_tl_hold", ra(0, 4), 32'h5);
    bus_write(ra(0, 8), 32'h4);
    check_irq("os_clear", 4'b0000);

    // W1C colliding with the overflow edge, then a later W1C.
    bus_write(ra(0, 0), 32'h0);
    bus_write(ra(0, 4), 32'hFFFF_FFFE);
    bus_write(ra(0, 8), 32'h3);
    tick();
    check_read("col_tl_max", ra(0, 4), 32'hFFFF_FFFF);
    bus_write(ra(0, 8), 32'h7);
    check_read("col_tcon", ra(0, 8), 32'h7);
    check_read("col_tl", ra(0, 4), 32'h0);
    check_irq("col_irq", 4'b0001);
    bus_write(ra(0, 8), 32'h7);
    check_read("col_tcon_late", ra(0, 8), 32'h3);
    check_irq("col_irq_late", 4'b0000);
    bus_write(ra(0, 8), 32'h0);

    // TL write on the overflow cycle beats the overflow.
    bus_write(ra(0, 4), 32'hFFFF_FFFE);
    bus_write(ra(0, 8), 32'h3);
    tick();
    check_read("tlw_tl_max", ra(0, 4), 32'hFFFF_FFFF);
    bus_write(ra(0, 4), 32'h10);
    check_read("tlw_tl", ra(0, 4), 32'h10);
    check_read("tlw_tcon", ra(0, 8), 32'h3);
    check_irq("tlw_irq", 4'b0000);
    bus_write(ra(0, 8), 32'h0);

    // Channels 1 and 2 overflow together; only channel 1 has IE.
    bus_write(ra(1, 0), 32'h100);
    bus_write(ra(2, 0), 32'h200);
    bus_write(ra(1, 4), 32'hFFFF_FFFE);
    bus_write(ra(2, 4), 32'hFFFF_FFFF);
    bus_write(ra(1, 8), 32'h3);
    bus_write(ra(2, 8), 32'h1);
    tick();
    check_irq("mc_irq", 4'b0010);
    check_read("mc_ch1_tl", ra(1, 4), 32'h100);
    check_read("mc_ch2_tl", ra(2, 4), 32'h200);
    check_read("mc_ch1_tcon", ra(1, 8), 32'h7);
    check_read("mc_ch2_tcon", ra(2, 8), 32'h1);
    check_read("mc_unmapped_ch4", B + 32'h40, 32'h0);
    check_read("mc_unmapped_off12", ra(1, 12), 32'h0);

    // rdata is zero without a read strobe.
    expect_val("no_rd_zero", 32'h0);
    addr = ra(1, 0);
    rd   = 1'b0;
    #1;
    compare_next(rdata);

    // Read and write of the same register in one cycle shows the old value.
    addr  = ra(3, 0);
    wdata = 32'hABCD;
    wr    = 1'b1;
    rd    = 1'b1;
    expect_val("rw_prewrite", 32'h0);
    #1;
    compare_next(rdata);
    tick();
    wr = 1'b0;
    rd = 1'b0;
    check_read("rw_postwrite", ra(3, 0), 32'hABCD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
